writeback_unit: RTL and testbench

- Writeback stage directly upstream of the register file.
- Drives the register file's single write port (wen/rd/dataD) from two sources:
  - the single-cycle ALU result;
  - variable-latency load results from the LSU, formatted (sign/zero extension) and buffered in a small FIFO.
- Keeps a per-register load-pending scoreboard so the issue logic can stall RAW/WAW hazards against outstanding loads.

---
 rtl/writeback_unit_pkg.sv | 20 ++
 rtl/writeback_unit_load_formatter.sv | 29 ++
 rtl/writeback_unit.sv | 138 +++++++++++++
 tb/tb_writeback_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared writeback definitions: load funct3 encodings, default widths, writeback entry.
package writeback_unit_pkg;

   localparam int XLEN    = 64;
   localparam int REG_AW  = 5;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LD  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_unit_load_formatter.sv
// Combinational load formatter: selects the addressed lane of a doubleword and extends it.
module writeback_unit_load_formatter
   import writeback_unit_pkg::*;
(
   input  logic [63:0] rdata_i,
   input  logic [2:0]  offset_i,
   input  logic [2:0]  funct3_i,
   output logic [63:0] data_o
);

   logic [63:0] shifted;

   assign shifted = rdata_i >> {offset_i, 3'b000};

   always_comb begin
      data_o = '0;
      case (funct3_i)
         LB:      data_o = {{56{shifted[7]}},  shifted[7:0]};
         LH:      data_o = {{48{shifted[15]}}, shifted[15:0]};
         LW:      data_o = {{32{shifted[31]}}, shifted[31:0]};
         LD:      data_o = shifted;
         LBU:     data_o = {56'd0, shifted[7:0]};
         LHU:     data_o = {48'd0, shifted[15:0]};
         LWU:     data_o = {32'd0, shifted[31:0]};
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: arbitrates ALU results and buffered load results onto the register file
// write port (1-cycle registered), and tracks outstanding loads per destination register.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_AW,
   parameter int DATA_WIDTH = XLEN,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alu_valid,
   input  logic [ADDR_WIDTH-1:0]        alu_rd,
   input  logic [DATA_WIDTH-1:0]        alu_data,
   input  logic                         lsu_valid,
   output logic                         lsu_ready,
   input  logic [ADDR_WIDTH-1:0]        lsu_rd,
   input  logic [63:0]                  lsu_rdata,
   input  logic [2:0]                   lsu_offset,
   input  logic [2:0]                   lsu_funct3,
   input  logic                         ld_issue_valid,
   input  logic [ADDR_WIDTH-1:0]        ld_issue_rd,
   output logic [(1<<ADDR_WIDTH)-1:0]   pending,
   output logic                         wen,
   output logic [ADDR_WIDTH-1:0]        rd,
   output logic [DATA_WIDTH-1:0]        dataD
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int NREG  = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] ld_data;
   logic [ADDR_WIDTH-1:0] fifo_rd_q   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  wen_q, wen_d;
   logic [ADDR_WIDTH-1:0] rd_q, rd_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [NREG-1:0]       pending_q, pending_d;

   logic                  fifo_empty, fifo_full, lsu_acc;
   logic                  sel_vld, sel_lsu, pop, bypass, push;
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;

   writeback_unit_load_formatter u_fmt (
      .rdata_i  (lsu_rdata),
      .offset_i (lsu_offset),
      .funct3_i (lsu_funct3),
      .data_o   (ld_data)
   );

   // Ready depends only on registered occupancy, never on this cycle's ALU traffic.
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign lsu_ready  = !fifo_full;
   assign lsu_acc    = lsu_valid && lsu_ready;
   assign push       = lsu_acc && !bypass;

   always_comb begin
      sel_vld  = 1'b0;
      sel_lsu  = 1'b0;
      sel_rd   = '0;
      sel_data = '0;
      pop      = 1'b0;
      bypass   = 1'b0;
      if (alu_valid) begin
         sel_vld  = 1'b1;
         sel_rd   = alu_rd;
         sel_data = alu_data;
      end else if (!fifo_empty) begin
         sel_vld  = 1'b1;
         sel_lsu  = 1'b1;
         pop      = 1'b1;
         sel_rd   = fifo_rd_q[rd_ptr_q];
         sel_data = fifo_data_q[rd_ptr_q];
      end else if (lsu_acc) begin
         sel_vld  = 1'b1;
         sel_lsu  = 1'b1;
         bypass   = 1'b1;
         sel_rd   = lsu_rd;
         sel_data = ld_data;
      end
   end

   always_comb begin
      wen_d  = sel_vld && (sel_rd != '0);
      rd_d   = sel_vld ? sel_rd : rd_q;
      data_d = sel_vld ? sel_data : data_q;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

      // Clear first so a same-cycle issue to the same register keeps the bit set.
      pending_d = pending_q;
      if (sel_vld && sel_lsu) pending_d[sel_rd] = 1'b0;
      if (ld_issue_valid)     pending_d[ld_issue_rd] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wen_q     <= 1'b0;
         rd_q      <= '0;
         data_q    <= '0;
         pending_q <= '0;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         wen_q     <= wen_d;
         rd_q      <= rd_d;
         data_q    <= data_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd_q[wr_ptr_q]   <= lsu_rd;
         fifo_data_q[wr_ptr_q] <= ld_data;
      end
   end

   assign wen     = wen_q;
   assign rd      = rd_q;
   assign dataD   = data_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit: arbitration, formatting, scoreboard, reset.
module tb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [63:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [63:0] lsu_rdata;
   logic [2:0]  lsu_offset;
   logic [2:0]  lsu_funct3;
   logic        ld_issue_valid;
   logic [4:0]  ld_issue_rd;
   logic [31:0] pending;
   logic        wen;
   logic [4:0]  rd;
   logic [63:0] dataD;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   writeback_unit dut (
      .clk            (clk),
      .rst            (rst),
      .alu_valid      (alu_valid),
      .alu_rd         (alu_rd),
      .alu_data       (alu_data),
      .lsu_valid      (lsu_valid),
      .lsu_ready      (lsu_ready),
      .lsu_rd         (lsu_rd),
      .lsu_rdata      (lsu_rdata),
      .lsu_offset     (lsu_offset),
      .lsu_funct3     (lsu_funct3),
      .ld_issue_valid (ld_issue_valid),
      .ld_issue_rd    (ld_issue_rd),
      .pending        (pending),
      .wen            (wen),
      .rd             (rd),
      .dataD          (dataD)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      alu_valid      = 1'b0;
      alu_rd         = '0;
      alu_data       = '0;
      lsu_valid      = 1'b0;
      lsu_rd         = '0;
      lsu_rdata      = '0;
      lsu_offset     = '0;
      lsu_funct3     = '0;
      ld_issue_valid = 1'b0;
      ld_issue_rd    = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [4:0] r, input logic [63:0] d, input logic [2:0] off,
                       input logic [2:0] f3);
      lsu_valid  = 1'b1;
      lsu_rd     = r;
      lsu_rdata  = d;
      lsu_offset = off;
      lsu_funct3 = f3;
   endtask

   // Formatter vectors: rdata, offset, funct3, expected
   logic [63:0] fv_rdata [8] = '{64'h00000000_80FF0000, 64'h00000000_80FF0000,
                                 64'h00000000_80FF0000, 64'h01234567_89ABCDEF,
                                 64'h01234567_89ABCDEF, 64'h00000000_80FF0000,
                                 64'hF234_0000_0000_0000, 64'h89ABCDEF_00000000};
   logic [2:0]  fv_off   [8] = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd3, 3'd6, 3'd4};
   logic [2:0]  fv_f3    [8] = '{3'b000, 3'b101, 3'b010, 3'b011, 3'b111, 3'b100, 3'b001, 3'b110};
   logic [63:0] fv_exp   [8] = '{64'hFFFFFFFF_FFFFFFFF, 64'h00000000_000080FF,
                                 64'hFFFFFFFF_80FF0000, 64'h01234567_89ABCDEF,
                                 64'h00000000_00000000, 64'h00000000_00000080,
                                 64'hFFFFFFFF_FFFFF234, 64'h00000000_89ABCDEF};

   // Contention scenario: ready before each edge, and write seen after it
   logic       ct_rdy  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   logic       ct_wen  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [4:0] ct_rd   [8] = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd8, 5'd9, 5'd10, 5'd10};
   logic       ct_acc  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      int lsu_idx;
      logic hs;
      logic [63:0] exp_d;

      idle();
      rst       = 1'b1;
      alu_valid = 1'b1;
      alu_rd    = 5'd9;
      alu_data  = 64'hDEAD;
      tick();
      tick();
      rst = 1'b0;
      idle();
      chk("rst_wen", {63'd0, wen}, 64'd0);
      chk("rst_rd", {59'd0, rd}, 64'd0);
      chk("rst_data", dataD, 64'd0);
      chk("rst_pending", {32'd0, pending}, 64'd0);
      chk("rst_ready", {63'd0, lsu_ready}, 64'd1);

      // Single ALU write, then hold
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
      tick();
      idle();
      chk("alu_wen", {63'd0, wen}, 64'd1);
      chk("alu_rd", {59'd0, rd}, 64'd5);
      chk("alu_data", dataD, 64'h1234);
      tick();
      chk("alu_wen_drop", {63'd0, wen}, 64'd0);
      chk("alu_rd_hold", {59'd0, rd}, 64'd5);

      // Bypass loads through the formatter
      for (int i = 0; i < 8; i++) begin
         load(5'd7, fv_rdata[i], fv_off[i], fv_f3[i]);
         tick();
         idle();
         chk($sformatf("fmt%0d_wen", i), {63'd0, wen}, 64'd1);
         chk($sformatf("fmt%0d_rd", i), {59'd0, rd}, 64'd7);
         chk($sformatf("fmt%0d_data", i), dataD, fv_exp[i]);
      end
      tick();

      // ALU priority with FIFO filling and draining in order
      lsu_idx = 0;
      for (int k = 0; k < 8; k++) begin
         alu_valid = (k < 4);
         alu_rd    = 5'(20 + k);
         alu_data  = 64'hA0 + 64'(k);
         if (lsu_idx < 3) load(5'(8 + lsu_idx), 64'h1000 + 64'(8 + lsu_idx), 3'd0, 3'b011);
         else lsu_valid = 1'b0;
         chk($sformatf("ct%0d_ready", k), {63'd0, lsu_ready}, {63'd0, ct_rdy[k]});
         hs = lsu_valid && lsu_ready;
         chk($sformatf("ct%0d_accept", k), {63'd0, hs}, {63'd0, ct_acc[k]});
         if (hs) lsu_idx++;
         tick();
         idle();
         exp_d = (k < 4) ? 64'hA0 + 64'(k) : 64'h1000 + 64'(ct_rd[k]);
         chk($sformatf("ct%0d_wen", k), {63'd0, wen}, {63'd0, ct_wen[k]});
         chk($sformatf("ct%0d_rd", k), {59'd0, rd}, {59'd0, ct_rd[k]});
         if (ct_wen[k]) chk($sformatf("ct%0d_data", k), dataD, exp_d);
      end

      // Scoreboard set and clear; another issue lands on the clearing edge
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd12;
      tick();
      idle();
      chk("sb_set12", {32'd0, pending}, 64'h1000);
      tick();
      chk("sb_hold12a", {32'd0, pending}, 64'h1000);
      tick();
      chk("sb_hold12b", {32'd0, pending}, 64'h1000);
      load(5'd12, 64'h55, 3'd0, 3'b011);
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd13;
      tick();
      idle();
      chk("sb_clr12_wen", {63'd0, wen}, 64'd1);
      chk("sb_clr12_rd", {59'd0, rd}, 64'd12);
      chk("sb_clr12_pend", {32'd0, pending}, 64'h2000);
      load(5'd13, 64'h66, 3'd0, 3'b011);
      tick();
      idle();
      chk("sb_clr13", {32'd0, pending}, 64'd0);

      // Register x0 is never written or tracked
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hBAD;
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
      tick();
      idle();
      chk("x0_alu_wen", {63'd0, wen}, 64'd0);
      chk("x0_pending", {32'd0, pending}, 64'd0);
      load(5'd0, 64'h77, 3'd0, 3'b011);
      chk("x0_ld_ready", {63'd0, lsu_ready}, 64'd1);
      tick();
      idle();
      chk("x0_ld_wen", {63'd0, wen}, 64'd0);
      tick();
      chk("x0_ld_nostale", {63'd0, wen}, 64'd0);
      chk("x0_ld_ready_after", {63'd0, lsu_ready}, 64'd1);

      // Reset with two buffered loads and a pending bit
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h11;
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd3;
      load(5'd14, 64'h14, 3'd0, 3'b011);
      tick();
      idle();
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'h22;
      load(5'd15, 64'h15, 3'd0, 3'b011);
      tick();
      idle();
      chk("pre_rst_ready", {63'd0, lsu_ready}, 64'd0);
      chk("pre_rst_pending", {32'd0, pending}, 64'h8);
      chk("pre_rst_wen", {63'd0, wen}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_wen", {63'd0, wen}, 64'd0);
      chk("mid_rst_pending", {32'd0, pending}, 64'd0);
      chk("mid_rst_ready", {63'd0, lsu_ready}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("post_rst%0d_wen", i), {63'd0, wen}, 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
